// File: rtl/lna_seq.sv
// LNA power-up / gain-mode sequencer: bias -> core enable -> settle -> ready.
// Optional macro LNA_SEQ_GAIN_RAMP_EN: ramp lna_mode one step per settle dwell.
module lna_seq #(
  parameter int BIAS_CYC   = 64,
  parameter int SETTLE_CYC = 32,
  parameter int CNT_W      = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pd_req,
  input  logic [1:0] mode_req,
  output logic       bias_en,
  output logic       lna_en,
  output logic [1:0] lna_mode,
  output logic       lna_rdy,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_OFF,
    S_BIAS,
    S_SETTLE,
    S_ON,
    S_MODE_SW,
    S_SHUTDOWN
  } state_e;

  localparam logic [CNT_W-1:0] BIAS_LOAD   = CNT_W'(BIAS_CYC - 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYC - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             bias_en_q, bias_en_d;
  logic             lna_en_q, lna_en_d;
  logic [1:0]       lna_mode_q, lna_mode_d;
  logic             lna_rdy_q, lna_rdy_d;
  logic [1:0]       step_mode;
  logic [CNT_W-1:0] cnt_dec;

  // Mode applied by one MODE_SW step.
  always_comb begin
`ifdef LNA_SEQ_GAIN_RAMP_EN
    if (mode_req > lna_mode_q) step_mode = lna_mode_q + 2'd1;
    else                       step_mode = lna_mode_q - 2'd1;
`else
    step_mode = mode_req;
`endif
  end

  // Saturating decrement keeps the dwell counter from wrapping.
  assign cnt_dec = (cnt_q != '0) ? cnt_q - 1'b1 : '0;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_dec;
    bias_en_d  = bias_en_q;
    lna_en_d   = lna_en_q;
    lna_mode_d = lna_mode_q;
    lna_rdy_d  = lna_rdy_q;

    unique case (state_q)
      S_OFF: begin
        bias_en_d  = 1'b0;
        lna_en_d   = 1'b0;
        lna_mode_d = '0;
        lna_rdy_d  = 1'b0;
        if (!pd_req) begin
          state_d   = S_BIAS;
          bias_en_d = 1'b1;
          cnt_d     = BIAS_LOAD;
        end
      end
      S_BIAS: begin
        if (pd_req) begin
          state_d   = S_SHUTDOWN;
          lna_en_d  = 1'b0;
          lna_rdy_d = 1'b0;
        end else if (cnt_q == '0) begin
          state_d    = S_SETTLE;
          lna_en_d   = 1'b1;
          lna_mode_d = mode_req;
          cnt_d      = SETTLE_LOAD;
        end
      end
      S_SETTLE: begin
        if (pd_req) begin
          state_d   = S_SHUTDOWN;
          lna_en_d  = 1'b0;
          lna_rdy_d = 1'b0;
        end else if (cnt_q == '0) begin
          state_d   = S_ON;
          lna_rdy_d = 1'b1;
        end
      end
      S_ON: begin
        if (pd_req) begin
          state_d   = S_SHUTDOWN;
          lna_en_d  = 1'b0;
          lna_rdy_d = 1'b0;
        end else if (mode_req != lna_mode_q) begin
          state_d    = S_MODE_SW;
          lna_rdy_d  = 1'b0;
          lna_mode_d = step_mode;
          cnt_d      = SETTLE_LOAD;
        end
      end
      S_MODE_SW: begin
        if (pd_req) begin
          state_d   = S_SHUTDOWN;
          lna_en_d  = 1'b0;
          lna_rdy_d = 1'b0;
        end else if (cnt_q == '0) begin
          if (mode_req == lna_mode_q) begin
            state_d   = S_ON;
            lna_rdy_d = 1'b1;
          end else begin
            lna_mode_d = step_mode;
            cnt_d      = SETTLE_LOAD;
          end
        end
      end
      S_SHUTDOWN: begin
        state_d    = S_OFF;
        bias_en_d  = 1'b0;
        lna_en_d   = 1'b0;
        lna_mode_d = '0;
        lna_rdy_d  = 1'b0;
      end
      default: begin
        state_d    = S_OFF;
        cnt_d      = '0;
        bias_en_d  = 1'b0;
        lna_en_d   = 1'b0;
        lna_mode_d = '0;
        lna_rdy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_OFF;
      cnt_q      <= '0;
      bias_en_q  <= 1'b0;
      lna_en_q   <= 1'b0;
      lna_mode_q <= '0;
      lna_rdy_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bias_en_q  <= bias_en_d;
      lna_en_q   <= lna_en_d;
      lna_mode_q <= lna_mode_d;
      lna_rdy_q  <= lna_rdy_d;
    end
  end

  assign bias_en  = bias_en_q;
  assign lna_en   = lna_en_q;
  assign lna_mode = lna_mode_q;
  assign lna_rdy  = lna_rdy_q;
  assign busy     = (state_q == S_BIAS) || (state_q == S_SETTLE) ||
                    (state_q == S_MODE_SW) || (state_q == S_SHUTDOWN);

endmodule

// File: tb/tb_lna_seq.sv
// Self-checking bench for lna_seq: directed sequences plus randomized traffic
// against a phase/elapsed-time reference model.
module tb_lna_seq;

  localparam int BIAS   = 4;
  localparam int SETTLE = 3;

  logic       clk;
  logic       rst;
  logic       pd_req;
  logic [1:0] mode_req;
  logic       bias_en;
  logic       lna_en;
  logic [1:0] lna_mode;
  logic       lna_rdy;
  logic       busy;

  int n_checks;
  int n_fail;

  // Reference model: phase 0 off, 1 bias, 2 settle, 3 on, 4 mode switch, 5 shutdown.
  int m_ph;
  int m_age;
  int m_mode;

  lna_seq #(
    .BIAS_CYC  (BIAS),
    .SETTLE_CYC(SETTLE),
    .CNT_W     (8)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .pd_req  (pd_req),
    .mode_req(mode_req),
    .bias_en (bias_en),
    .lna_en  (lna_en),
    .lna_mode(lna_mode),
    .lna_rdy (lna_rdy),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int next_mode(input int cur, input int req);
`ifdef LNA_SEQ_GAIN_RAMP_EN
    return (req > cur) ? cur + 1 : cur - 1;
`else
    return req;
`endif
  endfunction

  task automatic model_reset();
    m_ph   = 0;
    m_age  = 0;
    m_mode = 0;
  endtask

  task automatic model_step(input int pd, input int req);
    if (pd != 0 && m_ph >= 1 && m_ph <= 4) begin
      m_ph = 5;
    end else begin
      case (m_ph)
        0: if (pd == 0) begin m_ph = 1; m_age = 0; end
        1: if (m_age == BIAS - 1) begin m_ph = 2; m_age = 0; m_mode = req; end
           else m_age++;
        2: if (m_age == SETTLE - 1) m_ph = 3;
           else m_age++;
        3: if (req != m_mode) begin m_ph = 4; m_age = 0; m_mode = next_mode(m_mode, req); end
        4: if (m_age == SETTLE - 1) begin
             if (req == m_mode) m_ph = 3;
             else begin m_mode = next_mode(m_mode, req); m_age = 0; end
           end else m_age++;
        default: begin m_ph = 0; m_mode = 0; end
      endcase
    end
  endtask

  task automatic compare_all();
    check("bias_en",  int'(bias_en),  (m_ph >= 1) ? 1 : 0);
    check("lna_en",   int'(lna_en),   (m_ph >= 2 && m_ph <= 4) ? 1 : 0);
    check("lna_mode", int'(lna_mode), m_mode);
    check("lna_rdy",  int'(lna_rdy),  (m_ph == 3) ? 1 : 0);
    check("busy",     int'(busy),     (m_ph == 0 || m_ph == 3) ? 0 : 1);
  endtask

  task automatic drive(input logic pd, input logic [1:0] m);
    pd_req   = pd;
    mode_req = m;
  endtask

  // One rising edge; the model consumes the inputs that were stable across it.
  task automatic tick();
    @(posedge clk);
    if (!rst) model_step(int'(pd_req), int'(mode_req));
    #1;
    compare_all();
  endtask

  task automatic run_to_on(input logic [1:0] m);
    drive(1'b0, m);
    for (int e = 1; e <= BIAS + SETTLE + 1; e++) begin
      tick();
      if (e == BIAS + SETTLE + 1) check("run_to_on_rdy", int'(lna_rdy), 1);
    end
  endtask

  int seen_en;
  int cnt;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    drive(1'b0, 2'd2);
    model_reset();
    #1;
    compare_all();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Power-up from reset release with mode 2.
    for (int e = 1; e <= 8; e++) begin
      tick();
      if (e == 1) check("pu_bias_e1", int'(bias_en), 1);
      if (e == 4) check("pu_lna_en_e4", int'(lna_en), 0);
      if (e == 5) begin
        check("pu_lna_en_e5", int'(lna_en), 1);
        check("pu_mode_e5", int'(lna_mode), 2);
      end
      if (e == 7) check("pu_rdy_e7", int'(lna_rdy), 0);
      if (e == 8) begin
        check("pu_rdy_e8", int'(lna_rdy), 1);
        check("pu_busy_e8", int'(busy), 0);
      end
    end

    // Power-down from ON.
    drive(1'b1, 2'd2);
    tick();
    check("pd_lna_en", int'(lna_en), 0);
    check("pd_rdy", int'(lna_rdy), 0);
    check("pd_bias_held", int'(bias_en), 1);
    tick();
    check("pd_bias_off", int'(bias_en), 0);
    check("pd_mode_zero", int'(lna_mode), 0);
    check("pd_busy", int'(busy), 0);

    // Mode change 0 -> 3 from ON.
    run_to_on(2'd0);
    drive(1'b0, 2'd3);
    tick();
    check("msw_rdy_drop", int'(lna_rdy), 0);
`ifdef LNA_SEQ_GAIN_RAMP_EN
    check("msw_mode_step1", int'(lna_mode), 1);
    repeat (3) tick();
    check("msw_mode_step2", int'(lna_mode), 2);
    repeat (3) tick();
    check("msw_mode_step3", int'(lna_mode), 3);
    check("msw_rdy_mid", int'(lna_rdy), 0);
`else
    check("msw_mode_jump", int'(lna_mode), 3);
`endif
    repeat (2) tick();
    check("msw_rdy_early", int'(lna_rdy), 0);
    tick();
    check("msw_rdy_final", int'(lna_rdy), 1);

    // Asynchronous reset in MODE_SW.
    drive(1'b0, 2'd1);
    tick();
    check("ar_in_msw", int'(busy), 1);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check("ar_bias", int'(bias_en), 0);
    check("ar_lna_en", int'(lna_en), 0);
    check("ar_mode", int'(lna_mode), 0);
    check("ar_rdy", int'(lna_rdy), 0);
    compare_all();
    tick();
    rst = 1'b0;
    drive(1'b0, 2'd2);
    for (int e = 1; e <= 8; e++) begin
      tick();
      if (e == 5) check("ar_pu_mode", int'(lna_mode), 2);
      if (e == 8) check("ar_pu_rdy", int'(lna_rdy), 1);
    end

    // Abort in the second BIAS cycle: core never enables.
    drive(1'b1, 2'd2);
    repeat (2) tick();
    drive(1'b0, 2'd2);
    seen_en = 0;
    repeat (2) begin
      tick();
      if (lna_en) seen_en = 1;
    end
    drive(1'b1, 2'd2);
    tick();
    if (lna_en) seen_en = 1;
    check("ab_shut_bias", int'(bias_en), 1);
    check("ab_shut_busy", int'(busy), 1);
    tick();
    if (lna_en) seen_en = 1;
    check("ab_off_bias", int'(bias_en), 0);
    check("ab_off_busy", int'(busy), 0);
    check("ab_never_en", seen_en, 0);

    // pd_req pulse back low during SHUTDOWN restarts a full sequence.
    run_to_on(2'd1);
    drive(1'b1, 2'd1);
    tick();
    drive(1'b0, 2'd1);
    tick();
    check("sp_off_bias", int'(bias_en), 0);
    check("sp_off_busy", int'(busy), 0);
    cnt = 0;
    while (!lna_rdy && cnt < 20) begin
      tick();
      cnt++;
    end
    check("sp_rdy_latency", cnt, 8);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      if (pd_req) begin
        if ($urandom_range(0, 3) == 0) pd_req = 1'b0;
      end else if ($urandom_range(0, 59) == 0) begin
        pd_req = 1'b1;
      end
      if ($urandom_range(0, 9) == 0) mode_req = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 499) == 0) begin
        rst = 1'b1;
        model_reset();
        #1;
        compare_all();
        tick();
        rst = 1'b0;
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
